data_wbuf: RTL and testbench
============================

Name: data_wbuf

Overview:
Posted-store write buffer between exe_stage's data_sram-style request port and the AXI bridge's data port, inside mycpu_top.
- Stores are accepted into a FIFO and acknowledged one cycle later; the buffer drains them to the bridge in the background.
- Loads bypass buffered stores unless they hit the same word, in which case they stall until the FIFO drains.
- Downstream, at most one transaction is outstanding at any time.

Parameters:
DEPTH, 4, number of store entries (power of two, >=2)
PTR_W, 2, log2(DEPTH)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset, sampled on rising aclk
cpu_req  in  1  core request valid
cpu_wr  in  1  1 = store, 0 = load
cpu_size  in  2  0 = byte, 1 = half, 2 = word
cpu_wstrb  in  4  store byte enables
cpu_addr  in  32  physical address
cpu_wdata  in  32  store data
cpu_addr_ok  out  1  request accepted this cycle
cpu_data_ok  out  1  response: load data valid, or store acknowledge
cpu_rdata  out  32  load data
mem_req  out  1  request to bridge
mem_wr  out  1  store flag to bridge
mem_size  out  2  size to bridge
mem_wstrb  out  4  byte enables to bridge
mem_addr  out  32  address to bridge
mem_wdata  out  32  data to bridge
mem_addr_ok  in  1  bridge accepted request
mem_data_ok  in  1  bridge response for the single outstanding transaction
mem_rdata  in  32  bridge load data
wbuf_empty  out  1  FIFO empty and no store in flight (used by ibar/dbar/idle)

Behaviour:
Storage and state:
- FIFO of DEPTH entries {addr, size, wstrb, wdata} with head/tail pointers of PTR_W+1 bits; full/empty derived from the MSB. Pointers wrap modulo DEPTH.
- Downstream FSM states: IDLE, WAIT_LD, WAIT_ST.
- Registered st_ack_q.

Reset (aresetn=0 at a rising edge):
- Pointers cleared, FSM to IDLE, st_ack_q=0.
- Outputs: cpu_addr_ok=0, cpu_data_ok=0, mem_req=0, wbuf_empty=1.
- Reset mid-operation discards all entries and any in-flight transaction; the bridge shares aresetn.

Store accept:
- cpu_addr_ok=1 combinationally when cpu_req & cpu_wr & !full & state!=WAIT_LD.
- On accept: push at tail; st_ack_q=1 next cycle, giving cpu_data_ok exactly 1 cycle after addr_ok.
- Push and pop in the same cycle are legal; count is unchanged.
- Full is evaluated on registered pointers, so a pop in the same cycle does not admit a push into a full FIFO.

Load hazard and accept:
- hit = any valid entry with addr[31:2] == cpu_addr[31:2], compared against registered entries only.
- A load is eligible when cpu_req & !cpu_wr & state==IDLE & !hit & !st_ack_q.
- Eligible load: mem_req=1, mem_wr=0, cpu fields passed through, cpu_addr_ok=mem_addr_ok. On mem_addr_ok the FSM goes to WAIT_LD.
- A load that hits stalls (cpu_addr_ok=0) while entries drain. It issues once no hit remains and the FSM is back in IDLE.

Drain:
- In IDLE, with no eligible load and the FIFO non-empty: mem_req=1, mem_wr=1, fields taken from the head.
- On mem_addr_ok: pop the head and go to WAIT_ST.
- An eligible load always has priority over drain.

Completion:
- WAIT_LD: cpu_data_ok=mem_data_ok and cpu_rdata=mem_rdata; go to IDLE on mem_data_ok.
- WAIT_ST: mem_data_ok is consumed internally (not forwarded); go to IDLE.
- mem_req=0 in both WAIT states.

Ordering and output rules:
- Core responses are delivered in acceptance order: stores are blocked during WAIT_LD, and a load is not accepted while a store ack is pending.
- cpu_data_ok = st_ack_q | (state==WAIT_LD & mem_data_ok); the two terms are never simultaneously 1.
- Accepted stores are architecturally committed; there is no flush input.
- wbuf_empty = empty & state!=WAIT_ST.

Test Plan:
- Reset: hold aresetn=0 for 2 cycles with cpu_req=1 -> cpu_addr_ok=0, cpu_data_ok=0, mem_req=0, wbuf_empty=1; first cycle after release behaves as IDLE/empty.
- Fill: mem_addr_ok=0, 5 back-to-back stores to 0x100, 0x104, 0x108, 0x10C, 0x110 -> addr_ok=1 for the first 4, each with data_ok 1 cycle later. 5th has addr_ok=0 until mem_addr_ok=1 pops head 0x100, then is accepted. Drain order at mem_addr is 0x100, 0x104, 0x108, 0x10C, 0x110.
- RAW hazard: store wdata=0xDEADBEEF to 0x1000_0004 buffered, then load 0x1000_0006 -> load addr_ok=0 until that store issues and its mem_data_ok returns. Load then issues with mem_wr=0, mem_addr=0x1000_0006, and cpu_rdata equals mem_rdata when cpu_data_ok=1.
- Bypass: store to 0x200 buffered, load to 0x300 in the same IDLE cycle the drain is possible -> mem_req carries the load first (mem_wr=0, mem_addr=0x300); the store drains after the load's data_ok.
- Load outstanding: load accepted (WAIT_LD), then store request -> store addr_ok=0 until the cycle after the load's cpu_data_ok; then accepted, ack the following cycle.
- Reset mid-drain: 3 entries buffered, FSM in WAIT_ST, aresetn=0 for 1 cycle -> wbuf_empty=1 and mem_req=0 next cycle, no stale store ever issued.

Source files
------------

// File: rtl/data_wbuf_if.sv
// Core-side request port and bridge-side data port of the posted-store write buffer.
// The environment (core + bridge) uses the master view; the buffer uses the slave view.
interface data_wbuf_if;
    logic        cpu_req;
    logic        cpu_wr;
    logic [1:0]  cpu_size;
    logic [3:0]  cpu_wstrb;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_addr_ok;
    logic        cpu_data_ok;
    logic [31:0] cpu_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    modport master (
        output cpu_req, cpu_wr, cpu_size, cpu_wstrb, cpu_addr, cpu_wdata,
        input  cpu_addr_ok, cpu_data_ok, cpu_rdata,
        input  mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport slave (
        input  cpu_req, cpu_wr, cpu_size, cpu_wstrb, cpu_addr, cpu_wdata,
        output cpu_addr_ok, cpu_data_ok, cpu_rdata,
        output mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/data_wbuf.sv
// Posted-store write buffer: stores are queued and acknowledged the next cycle, loads
// bypass unless they hit a buffered word, and at most one bridge transaction is in flight.
module data_wbuf #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic       aclk,
    input  logic       aresetn,
    data_wbuf_if.slave bus,
    output logic       wbuf_empty
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_LD = 2'd1,
        S_WAIT_ST = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [PTR_W:0] head_q, head_d, tail_q, tail_d;
    logic           st_ack_q, st_ack_d;

    logic [31:0] addr_q  [DEPTH];
    logic [1:0]  size_q  [DEPTH];
    logic [3:0]  wstrb_q [DEPTH];
    logic [31:0] wdata_q [DEPTH];

    logic [PTR_W-1:0] head_idx_s, tail_idx_s;
    logic [PTR_W:0]   count_s;
    logic             empty_s, full_s, hit_s;
    logic             st_acc_s, ld_elig_s, drain_s, push_s, pop_s;

    assign head_idx_s = head_q[PTR_W-1:0];
    assign tail_idx_s = tail_q[PTR_W-1:0];
    assign count_s    = tail_q - head_q;
    assign empty_s    = (head_q == tail_q);
    assign full_s     = (head_q[PTR_W] != tail_q[PTR_W]) && (head_idx_s == tail_idx_s);

    // Word-address hazard against entries that are still queued (registered state only)
    always_comb begin
        logic [PTR_W-1:0] off_v;
        off_v = '0;
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off_v = PTR_W'(i) - head_idx_s;
            if (({1'b0, off_v} < count_s) && (addr_q[i][31:2] == bus.cpu_addr[31:2])) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Request classification; everything is gated while reset is asserted
    always_comb begin
        st_acc_s  = aresetn & bus.cpu_req & bus.cpu_wr & ~full_s & (state_q != S_WAIT_LD);
        ld_elig_s = aresetn & bus.cpu_req & ~bus.cpu_wr & (state_q == S_IDLE) & ~hit_s & ~st_ack_q;
        drain_s   = aresetn & (state_q == S_IDLE) & ~ld_elig_s & ~empty_s;
        push_s    = st_acc_s;
        pop_s     = drain_s & bus.mem_addr_ok;
    end

    // Pointer and store-ack next-state
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        st_ack_d = push_s;
        if (pop_s) begin
            head_d = head_q + {{PTR_W{1'b0}}, 1'b1};
        end else begin
            head_d = head_q;
        end
        if (push_s) begin
            tail_d = tail_q + {{PTR_W{1'b0}}, 1'b1};
        end else begin
            tail_d = tail_q;
        end
    end

    // Pointer and store-ack registers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            head_q   <= '0;
            tail_q   <= '0;
            st_ack_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            st_ack_q <= st_ack_d;
        end
    end

    // Entry payload; validity comes purely from the pointers, so no reset is needed
    always_ff @(posedge aclk) begin
        if (push_s) begin
            addr_q[tail_idx_s]  <= bus.cpu_addr;
            size_q[tail_idx_s]  <= bus.cpu_size;
            wstrb_q[tail_idx_s] <= bus.cpu_wstrb;
            wdata_q[tail_idx_s] <= bus.cpu_wdata;
        end
    end

    // Downstream FSM state register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Downstream FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ld_elig_s && bus.mem_addr_ok) begin
                    state_d = S_WAIT_LD;
                end else if (pop_s) begin
                    state_d = S_WAIT_ST;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_LD, S_WAIT_ST: begin
                if (bus.mem_data_ok) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Downstream FSM outputs: an eligible load wins over draining the head
    always_comb begin
        bus.mem_req     = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_size    = size_q[head_idx_s];
        bus.mem_wstrb   = wstrb_q[head_idx_s];
        bus.mem_addr    = addr_q[head_idx_s];
        bus.mem_wdata   = wdata_q[head_idx_s];
        bus.cpu_addr_ok = st_acc_s | (ld_elig_s & bus.mem_addr_ok);
        bus.cpu_data_ok = aresetn & (st_ack_q | ((state_q == S_WAIT_LD) & bus.mem_data_ok));
        bus.cpu_rdata   = bus.mem_rdata;
        wbuf_empty      = ~aresetn | (empty_s & (state_q != S_WAIT_ST));
        if (ld_elig_s) begin
            bus.mem_req   = 1'b1;
            bus.mem_wr    = 1'b0;
            bus.mem_size  = bus.cpu_size;
            bus.mem_wstrb = bus.cpu_wstrb;
            bus.mem_addr  = bus.cpu_addr;
            bus.mem_wdata = bus.cpu_wdata;
        end else if (drain_s) begin
            bus.mem_req = 1'b1;
            bus.mem_wr  = 1'b1;
        end else begin
            bus.mem_req = 1'b0;
        end
    end

endmodule

// File: tb/tb_data_wbuf.sv
// Scoreboard bench for data_wbuf: a core driver, a bridge model with its own memory,
// and a response monitor checked against a flat memory model updated at store acceptance.
module tb_data_wbuf;

    logic aclk = 1'b0;
    logic aresetn;
    logic wbuf_empty;

    data_wbuf_if bus ();

    data_wbuf #(.DEPTH(4), .PTR_W(2)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .bus        (bus),
        .wbuf_empty (wbuf_empty)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic is_st; logic [31:0] data; int cyc; } resp_t;
    typedef struct { logic [31:0] addr; logic [1:0] size; logic [3:0] wstrb; logic [31:0] wdata; } st_t;

    resp_t       resp_q [$];
    st_t         drain_q [$];
    logic [31:0] model_mem [logic [29:0]];
    logic [31:0] br_mem [logic [29:0]];

    int   vectors = 0, miscompares = 0, cycle = 0;
    int   bridge_mode = 0, lat_min = 0, lat_max = 0;
    int   last_ld_resp_cyc = -1, last_st_resp_cyc = -1, last_st_hs_cyc = -1;
    logic br_busy = 1'b0;

    function automatic logic [31:0] init_word(input logic [29:0] w);
        return {w, 2'b00} ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [3:0] strb_of(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    return 4'b0001 << off;
            2'd1:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] st, input logic [31:0] d);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial forever begin
        @(posedge aclk);
        cycle++;
    end

    // Response monitor: every cpu_data_ok consumes the oldest expected response
    initial begin : monitor
        resp_t r;
        forever begin
            @(negedge aclk);
            if (aresetn && bus.cpu_data_ok) begin
                if (resp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_data_ok: cpu_data_ok=1 with no request outstanding (cycle %0d)", cycle);
                end else begin
                    r = resp_q.pop_front();
                    if (r.is_st) begin
                        chk("st_ack_cycle", 32'(cycle), 32'(r.cyc + 1));
                    end else begin
                        chk("ld_rdata", bus.cpu_rdata, r.data);
                        last_ld_resp_cyc = cycle;
                    end
                end
            end
        end
    end

    // Bridge model: one outstanding transaction, its own memory, drain order checked
    initial begin : bridge
        logic        bwr;
        logic [31:0] baddr;
        int          lat;
        st_t         s;
        bwr = 1'b0; baddr = 32'h0; lat = 0;
        bus.mem_addr_ok = 1'b0;
        bus.mem_data_ok = 1'b0;
        bus.mem_rdata   = 32'h0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                br_busy = 1'b0;
            end else begin
                if (bus.mem_data_ok) begin
                    br_busy = 1'b0;
                    if (bwr) last_st_resp_cyc = cycle;
                end
                if (bus.mem_req && bus.mem_addr_ok) begin
                    br_busy = 1'b1;
                    bwr     = bus.mem_wr;
                    baddr   = bus.mem_addr;
                    lat     = $urandom_range(lat_max, lat_min);
                    if (bus.mem_wr) begin
                        last_st_hs_cyc = cycle;
                        if (drain_q.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_drain: store to %h issued with none buffered", bus.mem_addr);
                        end else begin
                            s = drain_q.pop_front();
                            chk("drain_addr", bus.mem_addr, s.addr);
                            chk("drain_size", 32'(bus.mem_size), 32'(s.size));
                            chk("drain_wstrb", 32'(bus.mem_wstrb), 32'(s.wstrb));
                            chk("drain_wdata", bus.mem_wdata, s.wdata);
                        end
                        br_mem[bus.mem_addr[31:2]] = merge(br_mem.exists(bus.mem_addr[31:2]) ?
                            br_mem[bus.mem_addr[31:2]] : init_word(bus.mem_addr[31:2]), bus.mem_wstrb, bus.mem_wdata);
                    end
                end
            end
            step();
            bus.mem_data_ok = 1'b0;
            if (br_busy) begin
                if (lat == 0) begin
                    bus.mem_data_ok = 1'b1;
                    bus.mem_rdata   = bwr ? $urandom : (br_mem.exists(baddr[31:2]) ? br_mem[baddr[31:2]] : init_word(baddr[31:2]));
                end else begin
                    lat--;
                end
            end
            bus.mem_addr_ok = br_busy ? 1'b0 : (bridge_mode == 1) ? 1'b1 :
                              (bridge_mode == 2) ? 1'($urandom_range(1, 0)) : 1'b0;
        end
    end

    task automatic drive(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        bus.cpu_req   = 1'b1;
        bus.cpu_wr    = wr;
        bus.cpu_size  = sz;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_wstrb = strb_of(sz, a[1:0]);
    endtask

    // Wait for acceptance, record the expectation, then drop the request on the next cycle
    task automatic wait_acc(input string name, output int acc_cyc, output int waited);
        logic [29:0] k;
        waited  = 0;
        acc_cyc = -1;
        forever begin
            @(negedge aclk);
            if (bus.cpu_addr_ok) begin
                acc_cyc = cycle;
                k = bus.cpu_addr[31:2];
                if (bus.cpu_wr) begin
                    resp_q.push_back('{1'b1, 32'h0, cycle});
                    drain_q.push_back('{bus.cpu_addr, bus.cpu_size, bus.cpu_wstrb, bus.cpu_wdata});
                    model_mem[k] = merge(model_mem.exists(k) ? model_mem[k] : init_word(k), bus.cpu_wstrb, bus.cpu_wdata);
                end else begin
                    chk("ld_issue_wr", 32'(bus.mem_wr), 32'h0);
                    chk("ld_issue_addr", bus.mem_addr, bus.cpu_addr);
                    resp_q.push_back('{1'b0, model_mem.exists(k) ? model_mem[k] : init_word(k), cycle});
                end
                break;
            end
            waited++;
            if (waited > 300) begin
                vectors++;
                miscompares++;
                $display("FAIL %s: no cpu_addr_ok within 300 cycles for addr %h", name, bus.cpu_addr);
                break;
            end
        end
        step();
        bus.cpu_req = 1'b0;
    endtask

    task automatic cpu_op(input string name, input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int acc, w;
        drive(wr, sz, a, d);
        wait_acc(name, acc, w);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        forever begin
            @(negedge aclk);
            if (wbuf_empty && !br_busy && resp_q.size() == 0) break;
            n++;
            if (n > 500) begin
                vectors++;
                miscompares++;
                $display("FAIL %s: buffer not idle within 500 cycles", name);
                break;
            end
        end
        step();
    endtask

    task automatic set_mode(input int m);
        @(negedge aclk);
        bridge_mode = m;
        step();
    endtask

    initial begin : main
        int          acc, w, acc_st, n;
        logic        wr;
        logic [1:0]  sz, off;
        logic [31:0] a;
        aresetn = 1'b0;
        drive(1'b1, 2'd2, 32'h0000_0100, 32'h1111_1111);

        repeat (2) begin
            @(negedge aclk);
            chk("rst_addr_ok", 32'(bus.cpu_addr_ok), 32'h0);
            chk("rst_data_ok", 32'(bus.cpu_data_ok), 32'h0);
            chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
            chk("rst_wbuf_empty", 32'(wbuf_empty), 32'h1);
        end
        step();
        aresetn     = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge aclk);
        chk("post_rst_empty", 32'(wbuf_empty), 32'h1);
        chk("post_rst_mem_req", 32'(bus.mem_req), 32'h0);
        step();

        // Fill with the bridge stalled; the fifth store waits for a pop
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd2, 32'h0000_0100 + 32'(4 * i), $urandom);
            wait_acc("fill", acc, w);
            chk("fill_first_try", 32'(w), 32'h0);
        end
        drive(1'b1, 2'd2, 32'h0000_0110, $urandom);
        repeat (3) begin
            @(negedge aclk);
            chk("fill_full_stall", 32'(bus.cpu_addr_ok), 32'h0);
        end
        bridge_mode = 1;
        wait_acc("fill_5th", acc, w);
        chk("fill_5th_after_pop", 32'(w), 32'h1);
        lat_max = 2;
        wait_idle("fill_drain");

        // Read-after-write hazard on the same word
        set_mode(0);
        drive(1'b1, 2'd2, 32'h1000_0004, 32'hDEAD_BEEF);
        wait_acc("raw_store", acc_st, w);
        drive(1'b0, 2'd1, 32'h1000_0006, 32'h0);
        repeat (3) begin
            @(negedge aclk);
            chk("raw_stall", 32'(bus.cpu_addr_ok), 32'h0);
        end
        bridge_mode = 1;
        wait_acc("raw_load", acc, w);
        chk("raw_store_resp_seen", 32'(last_st_resp_cyc > acc_st), 32'h1);
        chk("raw_load_after_store", 32'(acc > last_st_resp_cyc), 32'h1);
        wait_idle("raw_idle");

        // Load bypasses a buffered store to another word
        set_mode(0);
        drive(1'b1, 2'd2, 32'h0000_0200, 32'hCAFE_0200);
        wait_acc("byp_store", acc_st, w);
        drive(1'b0, 2'd2, 32'h0000_0300, 32'h0);
        @(negedge aclk);
        @(negedge aclk);
        chk("byp_mem_req", 32'(bus.mem_req), 32'h1);
        chk("byp_mem_wr", 32'(bus.mem_wr), 32'h0);
        chk("byp_mem_addr", bus.mem_addr, 32'h0000_0300);
        bridge_mode = 1;
        wait_acc("byp_load", acc, w);
        wait_idle("byp_idle");
        chk("byp_store_after_load", 32'(last_st_hs_cyc > last_ld_resp_cyc), 32'h1);

        // Store blocked while a load is outstanding
        lat_min = 3;
        lat_max = 3;
        cpu_op("ldout_load", 1'b0, 2'd2, 32'h0000_0400, 32'h0);
        drive(1'b1, 2'd2, 32'h0000_0404, 32'h0404_0404);
        repeat (2) begin
            @(negedge aclk);
            chk("ldout_st_block", 32'(bus.cpu_addr_ok), 32'h0);
        end
        wait_acc("ldout_store", acc, w);
        chk("ldout_st_after_resp", 32'(acc), 32'(last_ld_resp_cyc + 1));
        lat_min = 0;
        lat_max = 2;
        wait_idle("ldout_idle");

        // Randomised traffic over a small word pool to provoke hazards
        set_mode(2);
        for (int i = 0; i < 250; i++) begin
            wr  = 1'($urandom_range(1, 0));
            sz  = 2'($urandom_range(2, 0));
            off = (sz == 2'd2) ? 2'd0 : (sz == 2'd1) ? {1'($urandom_range(1, 0)), 1'b0} : 2'($urandom_range(3, 0));
            a   = 32'h1000_0000 + {27'd0, 3'($urandom_range(7, 0)), 2'b00} + {30'd0, off};
            cpu_op("rand", wr, sz, a, $urandom);
            n = $urandom_range(2, 0);
            repeat (n) step();
        end
        wait_idle("rand_idle");
        chk("rand_drain_left", 32'(drain_q.size()), 32'h0);

        // Reset while a store is in flight and two are still queued
        set_mode(0);
        lat_min = 6;
        lat_max = 6;
        for (int i = 0; i < 3; i++) cpu_op("mid_fill", 1'b1, 2'd2, 32'h0000_0500 + 32'(4 * i), $urandom);
        step();
        step();
        @(negedge aclk);
        bridge_mode = 1;
        n = 0;
        forever begin
            @(negedge aclk);
            if (bus.mem_req && bus.mem_wr && bus.mem_addr_ok) break;
            n++;
            if (n > 50) begin
                vectors++;
                miscompares++;
                $display("FAIL mid_issue: no drain handshake within 50 cycles");
                break;
            end
        end
        bridge_mode = 0;
        step();
        aresetn = 1'b0;
        @(negedge aclk);
        chk("mid_rst_empty", 32'(wbuf_empty), 32'h1);
        chk("mid_rst_mem_req", 32'(bus.mem_req), 32'h0);
        resp_q.delete();
        drain_q.delete();
        step();
        aresetn = 1'b1;
        @(negedge aclk);
        chk("mid_post_empty", 32'(wbuf_empty), 32'h1);
        bridge_mode = 1;
        repeat (10) begin
            @(negedge aclk);
            chk("mid_no_stale_req", 32'(bus.mem_req), 32'h0);
        end
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
